modport_en_receiver: RTL and testbench
======================================

# modport_en_receiver

Consumer end of the `Interface66` enable protocol. It attaches to the interface through the `mon` modport, where `en` is an input, and turns rising edges of `en` into counted events. Events are buffered in a saturating pending counter and handed downstream one at a time over a valid/ready handshake. It sits opposite any module that drives `en` through the `port` modport.

## Interface

Parameters:
- `WIDTH`, 4: width of the pending-event counter; capacity is 2^WIDTH−1 events.
- `TOTAL_WIDTH`, 16: width of the free-running total-event counter.
- `TIMEOUT`, 8: maximum number of consecutive cycles `en` may stay high; used only when the configuration macro is defined.

Ports:
- `i_clk`  input  1  clock; all logic on the rising edge.
- `i_rst_n`  input  1  asynchronous active-low reset.
- `a`  interface  —  `Interface66.mon`; `a.en` is an input.
- `i_ready`  input  1  downstream accepts one event.
- `o_valid`  output  1  at least one event is pending.
- `o_pending`  output  WIDTH  number of pending events.
- `i_clear`  input  1  synchronous clear of `o_overflow`, `o_total` and `o_stuck`.
- `o_overflow`  output  1  sticky flag: an event was dropped at saturation.
- `o_total`  output  TOTAL_WIDTH  count of all detected events, modulo 2^TOTAL_WIDTH.
- `o_stuck`  output  1  sticky flag: `en` was high for more than TIMEOUT cycles (macro only).

## Operation

- Edge detection: `en_q` registers `a.en`. An event fires in a cycle where `a.en`=1 and `en_q`=0. `en` held high counts as one event.
- Pop: fires when `o_valid` && `i_ready`.
- Pending counter update:
  - push only: +1, unless the counter is at 2^WIDTH−1. At saturation the count holds and `o_overflow` is set.
  - pop only: −1.
  - push and pop together: count unchanged, no overflow, even at saturation.
- `o_valid` = (`o_pending` != 0), decoded combinationally from the counter register.
- `o_total` increments on every event, including events dropped at saturation. It wraps from 2^TOTAL_WIDTH−1 to 0.
- FSM on `a.en`:
  - IDLE: `en_q`=0. Goes to ACTIVE on an event.
  - ACTIVE: high-run counter increments each cycle `a.en`=1.
    - returns to IDLE when `a.en`=0;
    - goes to STUCK when the run exceeds TIMEOUT (macro only).
  - STUCK: sets `o_stuck`; no further events while high; returns to IDLE when `a.en`=0.
- `i_clear` takes priority over a set in the same cycle: the flag reads 0 next cycle. When `i_clear` and an event coincide, `o_total` loads 1. `i_clear` does not affect the pending counter.
- Reset, asynchronous, including mid-operation:
  - `o_pending`=0, `o_valid`=0, `o_overflow`=0, `o_total`=0, `o_stuck`=0;
  - `en_q`=0, FSM=IDLE, run counter=0.
  - If `en` is already high when reset releases, that counts as one event.

## Timing

- `a.en` rise in cycle N → `o_pending`/`o_valid` updated at the edge ending N; visible in cycle N+1. Latency is 1 cycle.
- Pop in cycle N → `o_pending` decremented from cycle N+1.
- `o_valid` does not depend combinationally on `i_ready`. `i_ready` may be asserted without `o_valid`; nothing happens.
- Back-to-back events need `en` low for at least 1 cycle between highs. Maximum event rate is 1 per 2 cycles.
- `o_stuck` rises at the edge after the (TIMEOUT+1)-th consecutive high cycle.

## Configuration

- Macro: `MODPORT_EN_RECEIVER_TIMEOUT_EN`.
- Defined:
  - the run counter (clog2(TIMEOUT+2) bits), the STUCK state and `o_stuck` are implemented;
  - the run counter saturates in STUCK.
- Undefined:
  - no run counter and no STUCK state;
  - `o_stuck` is tied to 0;
  - `en` may stay high indefinitely as one event.

## Test plan

- Reset, then three 1-cycle `en` pulses spaced by 2 low cycles, `i_ready`=0 → `o_pending`=3, `o_valid`=1, `o_total`=3.
- Pending=3, `i_ready`=1 with no events → `o_pending` reads 2, 1, 0 on successive cycles. `o_valid` drops in the cycle `o_pending` reaches 0.
- WIDTH=4, `i_ready`=0, 16 events → `o_pending`=15, `o_overflow`=1, `o_total`=16. A 17th event with `i_ready`=1 in the same cycle → `o_pending` stays 15, `o_total`=17.
- Event coincident with a pop at `o_pending`=5 → `o_pending` stays 5. `i_clear` coincident with an event → `o_total`=1, `o_overflow`=0.
- Macro defined, TIMEOUT=8, `en` high for 12 cycles → 1 event; `o_stuck`=1 after the 9th high cycle; `o_stuck` remains 1 after `en` falls; `i_clear` → `o_stuck`=0. Macro undefined → `o_stuck` stays 0.
- Assert `i_rst_n`=0 asynchronously between clock edges with `o_pending`=7 and `en` high → all outputs 0 immediately. Release with `en` still high → one event; `o_pending`=1 in the next cycle.

Source files
------------

// File: rtl/modport_en_receiver_if.sv
// Interface66: single-wire enable protocol; the driver uses `port`, consumers use `mon`.
interface Interface66;
    logic en;

    modport port (output en);
    modport mon  (input  en);
endinterface

// File: rtl/modport_en_receiver.sv
// Consumer of the Interface66 enable: counts rising edges of en and hands them downstream over valid/ready.
// Optional stuck-high watchdog is built in when MODPORT_EN_RECEIVER_TIMEOUT_EN is defined.
module modport_en_receiver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TOTAL_WIDTH = 16,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    Interface66.mon                a,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_pending,
    input  logic                   i_clear,
    output logic                   o_overflow,
    output logic [TOTAL_WIDTH-1:0] o_total,
    output logic                   o_stuck
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STUCK  = 2'd2
    } state_t;

    logic                   en_q;
    logic                   evt;
    logic                   pop;
    logic                   ovf_set;
    logic [WIDTH-1:0]       pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic [TOTAL_WIDTH-1:0] total_q, total_d;
    state_t                 state_q;

    assign evt = a.en & ~en_q;
    assign pop = o_valid & i_ready;

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        unique case ({evt, pop})
            2'b10: begin
                if (&pend_q) ovf_set = 1'b1;
                else         pend_d  = pend_q + 1'b1;
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    // Clear wins over a same-cycle set; a coincident event still counts as the first one.
    always_comb begin
        ovf_d   = i_clear ? 1'b0 : (ovf_q | ovf_set);
        total_d = i_clear ? {{(TOTAL_WIDTH-1){1'b0}}, evt}
                          : total_q + {{(TOTAL_WIDTH-1){1'b0}}, evt};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q    <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
        end else begin
            en_q    <= a.en;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
        end
    end

    assign o_pending  = pend_q;
    assign o_valid    = (pend_q != '0);
    assign o_overflow = ovf_q;
    assign o_total    = total_q;

`ifdef MODPORT_EN_RECEIVER_TIMEOUT_EN
    localparam int unsigned RUN_W = $clog2(TIMEOUT + 2);

    logic [RUN_W-1:0] run_q;
    logic             stuck_q;

    // run_q holds the number of high cycles seen so far; it freezes once STUCK is reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            stuck_q <= 1'b0;
        end else begin
            if (i_clear) stuck_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (evt) begin
                        run_q <= RUN_W'(1);
                        if (TIMEOUT == 0) begin
                            state_q <= S_STUCK;
                            if (!i_clear) stuck_q <= 1'b1;
                        end else begin
                            state_q <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!a.en) begin
                        state_q <= S_IDLE;
                        run_q   <= '0;
                    end else begin
                        run_q <= run_q + 1'b1;
                        if (run_q >= RUN_W'(TIMEOUT)) begin
                            state_q <= S_STUCK;
                            if (!i_clear) stuck_q <= 1'b1;
                        end
                    end
                end
                S_STUCK: begin
                    if (!a.en) begin
                        state_q <= S_IDLE;
                        run_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    run_q   <= '0;
                end
            endcase
        end
    end

    assign o_stuck = stuck_q;
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (evt)   state_q <= S_ACTIVE;
                S_ACTIVE: if (!a.en) state_q <= S_IDLE;
                default:             state_q <= S_IDLE;
            endcase
        end
    end

    assign o_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_modport_en_receiver.sv
// Bench for modport_en_receiver: vector table, corner sequences and a randomized run against a reference model.
module tb_modport_en_receiver;
    localparam int WIDTH   = 4;
    localparam int TW      = 16;
    localparam int TIMEOUT = 8;
    localparam int PMAX    = (1 << WIDTH) - 1;
`ifdef MODPORT_EN_RECEIVER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready = 1'b0;
    logic          clear = 1'b0;
    logic          valid;
    logic [WIDTH-1:0] pending;
    logic          overflow;
    logic [TW-1:0] total;
    logic          stuck;

    Interface66 a_if ();

    modport_en_receiver #(.WIDTH(WIDTH), .TOTAL_WIDTH(TW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .a(a_if), .i_ready(ready), .o_valid(valid),
        .o_pending(pending), .i_clear(clear), .o_overflow(overflow), .o_total(total),
        .o_stuck(stuck)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_if.en = 1'b0; ready = 1'b0; clear = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            a_if.en = 1'b1; tick();
            a_if.en = 1'b0; tick();
        end
    endtask

    typedef struct {
        logic en, rdy, clr;
        int   pend;
        logic vld, ovf;
        int   tot;
    } vec_t;

    vec_t vecs[17];

    // Reference model state
    int m_pend, m_total, m_run;
    bit m_ovf, m_stuck, m_prev;

    task automatic model_reset();
        m_pend = 0; m_total = 0; m_run = 0; m_ovf = 0; m_stuck = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit e, input bit r, input bit c);
        bit ev, pp, oset, sset;
        ev   = e && !m_prev;
        pp   = (m_pend > 0) && r;
        oset = 0;
        if (ev && !pp) begin
            if (m_pend == PMAX) oset = 1;
            else                m_pend++;
        end else if (pp && !ev) begin
            m_pend--;
        end
        m_total = c ? int'(ev) : (m_total + int'(ev)) % (1 << TW);
        m_ovf   = c ? 1'b0 : (m_ovf | oset);
        m_run   = e ? m_run + 1 : 0;
        sset    = TO_EN && e && (m_run == TIMEOUT + 1);
        m_stuck = c ? 1'b0 : (m_stuck | sset);
        m_prev  = e;
    endtask

    initial begin
        //           en rdy clr pend vld ovf tot
        vecs[0]  = '{1, 0, 0, 1, 1, 0, 1};
        vecs[1]  = '{0, 0, 0, 1, 1, 0, 1};
        vecs[2]  = '{0, 0, 0, 1, 1, 0, 1};
        vecs[3]  = '{1, 0, 0, 2, 1, 0, 2};
        vecs[4]  = '{0, 0, 0, 2, 1, 0, 2};
        vecs[5]  = '{0, 0, 0, 2, 1, 0, 2};
        vecs[6]  = '{1, 0, 0, 3, 1, 0, 3};
        vecs[7]  = '{0, 1, 0, 2, 1, 0, 3};
        vecs[8]  = '{0, 1, 0, 1, 1, 0, 3};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 3};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 3};
        vecs[11] = '{1, 0, 0, 1, 1, 0, 4};
        vecs[12] = '{0, 1, 0, 0, 0, 0, 4};
        vecs[13] = '{1, 0, 1, 1, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 1, 1, 0, 1};
        vecs[15] = '{1, 1, 0, 1, 1, 0, 2};
        vecs[16] = '{0, 1, 0, 0, 0, 0, 2};

        a_if.en = 1'b0;
        do_reset();
        chk("reset_pend", 32'(pending), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_total", 32'(total), 0);
        chk("reset_ovf", 32'(overflow), 0);
        chk("reset_stuck", 32'(stuck), 0);

        for (int i = 0; i < 17; i++) begin
            a_if.en = vecs[i].en; ready = vecs[i].rdy; clear = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_total", i), 32'(total), 32'(vecs[i].tot));
            chk($sformatf("vec%0d_stuck", i), 32'(stuck), 0);
        end

        // Saturation and overflow
        do_reset();
        pulses(16);
        chk("sat_pend", 32'(pending), PMAX);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_total", 32'(total), 16);
        a_if.en = 1'b1; ready = 1'b1; tick();
        chk("sat_pushpop_pend", 32'(pending), PMAX);
        chk("sat_pushpop_total", 32'(total), 17);
        a_if.en = 1'b0;
        repeat (10) tick();
        chk("drain_pend", 32'(pending), 5);
        a_if.en = 1'b1; tick();
        chk("pushpop5_pend", 32'(pending), 5);
        chk("pushpop5_total", 32'(total), 18);
        a_if.en = 1'b0; ready = 1'b0; tick();
        a_if.en = 1'b1; clear = 1'b1; tick();
        clear = 1'b0; a_if.en = 1'b0;
        chk("clr_evt_total", 32'(total), 1);
        chk("clr_evt_ovf", 32'(overflow), 0);
        chk("clr_evt_pend", 32'(pending), 6);

        // Long high run
        do_reset();
        a_if.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("run%0d_stuck", k), 32'(stuck), 32'(TO_EN && k >= TIMEOUT + 1));
        end
        chk("run_pend", 32'(pending), 1);
        chk("run_total", 32'(total), 1);
        a_if.en = 1'b0; tick();
        chk("run_fall_stuck", 32'(stuck), 32'(TO_EN));
        clear = 1'b1; tick(); clear = 1'b0;
        chk("run_clr_stuck", 32'(stuck), 0);
        chk("run_clr_total", 32'(total), 0);

        // Asynchronous reset mid-cycle, released with en still high
        do_reset();
        pulses(6);
        a_if.en = 1'b1; tick();
        chk("pre_rst_pend", 32'(pending), 7);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pend", 32'(pending), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_total", 32'(total), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_stuck", 32'(stuck), 0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_rel_pend", 32'(pending), 1);
        chk("arst_rel_valid", 32'(valid), 1);
        chk("arst_rel_total", 32'(total), 1);
        a_if.en = 1'b0;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        begin
            int rdy_pct;
            bit e, r, c;
            rdy_pct = 50;
            e = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (cyc % 200 == 0) rdy_pct = $urandom_range(0, 100);
                if ($urandom_range(0, 3) == 0) e = ~e;
                r = ($urandom_range(0, 99) < rdy_pct);
                c = ($urandom_range(0, 63) == 0);
                a_if.en = e; ready = r; clear = c;
                model_step(e, r, c);
                tick();
                chk($sformatf("rnd%0d_pend", cyc), 32'(pending), 32'(m_pend));
                chk($sformatf("rnd%0d_total", cyc), 32'(total), 32'(m_total));
                chk($sformatf("rnd%0d_flags", cyc), {29'd0, valid, overflow, stuck},
                    {29'd0, (m_pend != 0), m_ovf, m_stuck});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
